wb_master_adapter: RTL
======================

// Module: wb_master_adapter
// PURPOSE
//  Native command/response (valid/ready) to Wishbone B4 classic-cycle master.
//  Sits upstream of a Wishbone slave adapter and the register banks behind it.
//  Used by CPU-side or test-side logic to issue single reads/writes.
//  One transaction outstanding at a time. A bus timeout turns a hung slave into an error response.
// PARAMETERS
//  ADDR_WIDTH      32   address width (cmd_addr, wb_adr_o)
//  DATA_WIDTH      32   data width; multiple of 8; SEL width = DATA_WIDTH/8
//  TIMEOUT_CYCLES  255  cycles in BUS before forced error; 0 = timeout disabled
// PORTS
//  wb_clk_i    in   1             clock, all logic on posedge
//  wb_rst_i    in   1             synchronous reset, active-high
//  cmd_valid   in   1             command request
//  cmd_ready   out  1             command accepted when valid&&ready
//  cmd_addr    in   ADDR_WIDTH    byte address
//  cmd_wdata   in   DATA_WIDTH    write data
//  cmd_we      in   1             1=write, 0=read
//  cmd_be      in   DATA_WIDTH/8  byte enables
//  rsp_valid   out  1             response available
//  rsp_ready   in   1             response consumed when valid&&ready
//  rsp_rdata   out  DATA_WIDTH    read data (0 for writes and errors)
//  rsp_err     out  1             1 = slave error or timeout
//  wb_adr_o    out  ADDR_WIDTH    WB address
//  wb_dat_o    out  DATA_WIDTH    WB write data
//  wb_dat_i    in   DATA_WIDTH    WB read data
//  wb_we_o     out  1             WB write enable
//  wb_sel_o    out  DATA_WIDTH/8  WB byte select
//  wb_cyc_o    out  1             WB cycle
//  wb_stb_o    out  1             WB strobe
//  wb_ack_i    in   1             WB acknowledge
//  wb_err_i    in   1             WB error
//  busy        out  1             state != IDLE
// BEHAVIOUR
//  Reset (sync): state=IDLE; cyc/stb/we/rsp_valid/rsp_err=0; adr/dat_o/sel/rsp_rdata=0; timer=0.
//  FSM IDLE -> BUS -> RESP -> IDLE.
//  IDLE: cmd_ready=1. On cmd_valid, register addr/wdata/we/be onto wb_*_o; timer=0; -> BUS.
//  BUS: cyc=stb=1; wb_adr/dat/we/sel held stable (classic cycle, stb held until termination).
//    - err_i=1 (wins over ack): rsp_err=1, rsp_rdata=0.
//    - else ack_i=1: rsp_err=0; rsp_rdata=wb_dat_i on reads, 0 on writes.
//    - else TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: rsp_err=1, rsp_rdata=0.
//    - else timer++.
//    On any of the three terminations: cyc=stb=0 at the same edge, -> RESP.
//  RESP: rsp_valid=1, rsp_* stable until rsp_ready; then -> IDLE with rsp_valid=0.
//  Latency: cmd accept at edge E, stb high from E, ack sampled at edge E+k, rsp_valid from E+k.
//    Against a 1-wait-state slave, k=2.
//  cmd_ready=0 in BUS and RESP. Back-to-back gap: at least one IDLE cycle between transactions.
//  Ack/err outside BUS (late or spurious) ignored. Ack and timeout on the same cycle: ack wins.
//  Reset mid-BUS: cyc/stb drop at the reset edge; no response produced.
//  Timer width $clog2(TIMEOUT_CYCLES+1), minimum 1. Saturating; never wraps.
// STRUCTURE
//  gemini_wb_pkg: typedef enum logic [1:0] {WBM_IDLE, WBM_BUS, WBM_RESP} wbm_state_e;
//    wbm_rsp_t struct {rdata, err}.
//  Sub-module wb_timeout_ctr (clear, enable, expired; param LIMIT; LIMIT=0 never expires).
//  All wb_*_o driven from flops. No combinational path from wb_*_i to wb_*_o.
// TESTING (bench pairs DUT with wb_slave_adapter + 4-word regfile)
//  1. Write 0xDEADBEEF to 0x4, be=0xF -> one reg_we pulse, ack at 2nd BUS cycle, rsp_err=0, rdata=0.
//  2. Read 0x4 after test 1 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
//  3. Stub slave never acks, TIMEOUT_CYCLES=8 -> cyc drops after 8 BUS cycles; rsp_err=1, rdata=0.
//  4. Slave drives ack=err=1 together -> rsp_err=1, rdata=0.
//  5. rsp_ready low 5 cycles after a read of 0x55AA55AA -> rsp stable, cmd_ready=0, no new cyc.
//  6. wb_rst_i in 1st BUS cycle -> next cycle cyc=stb=busy=rsp_valid=0, cmd_ready=1.

Source files
------------

// File: rtl/gemini_wb_pkg.sv
// Shared types and helpers for the Wishbone master adapter and its timeout counter.
package gemini_wb_pkg;

    // Master adapter sequencing: accept a command, run one classic cycle, hold the response.
    typedef enum logic [1:0] {
        WBM_IDLE = 2'd0,
        WBM_BUS  = 2'd1,
        WBM_RESP = 2'd2
    } wbm_state_e;

    // Widest data bus the response record can carry; adapters narrower than this
    // zero-extend into it and only present their low DATA_WIDTH bits.
    localparam int unsigned WBM_RDATA_W = 64;

    // Response record held in RESP until the consumer takes it.
    typedef struct packed {
        logic [WBM_RDATA_W-1:0] rdata;
        logic                   err;
    } wbm_rsp_t;

    // Width of a counter that must reach 'limit' without wrapping; never below one bit.
    function automatic int unsigned wbm_timer_width(input int unsigned limit);
        int unsigned w;
        if (limit == 0) begin
            w = 1;
        end else begin
            w = $clog2(limit + 1);
            if (w < 1) begin
                w = 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating bus-cycle timer. Flags 'expired' on the last permitted cycle
// (count == LIMIT-1) so the owner can terminate on that same edge.
// LIMIT = 0 disables expiry altogether.
module wb_timeout_ctr
    import gemini_wb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = wbm_timer_width(LIMIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Next count: clear has priority, otherwise count up while enabled and stick at LIMIT.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    generate
        if (LIMIT == 0) begin : g_no_limit
            logic count_unused;
            assign count_unused = ^count_reg;
            assign expired      = 1'b0;
        end else begin : g_limit
            localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);
            assign expired = (count_reg == CNT_LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_master_adapter.sv
// Valid/ready command/response front end driving a Wishbone B4 classic-cycle master.
// One transaction in flight; a hung slave is converted into an error response by a
// bus timer. Every wb_*_o comes straight from a flop so no input reaches an output
// combinationally.
module wb_master_adapter
    import gemini_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    // command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic                    cmd_we,
    input  logic [DATA_WIDTH/8-1:0] cmd_be,
    // response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // Wishbone master
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    // status
    output logic                    busy
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

    wbm_state_e              state_reg;
    logic                    cmd_ready_reg;
    logic [ADDR_WIDTH-1:0]   adr_reg;
    logic [DATA_WIDTH-1:0]   dat_reg;
    logic                    we_reg;
    logic [SEL_WIDTH-1:0]    sel_reg;
    logic                    cyc_reg;
    logic                    stb_reg;
    logic                    rsp_valid_reg;
    wbm_rsp_t                rsp_reg;

    logic                    cmd_accept;
    logic                    timer_expired;

    assign cmd_accept = (state_reg == WBM_IDLE) && cmd_valid;

    // Bus timer: restarted on every accepted command, runs only while the cycle is open.
    wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (wb_clk_i),
        .srst    (wb_rst_i),
        .clear   (cmd_accept),
        .enable  (state_reg == WBM_BUS),
        .expired (timer_expired)
    );

    // Transaction sequencer: latches the command onto the bus, waits for ack/err/timeout,
    // then parks the response until the consumer takes it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg     <= WBM_IDLE;
            cmd_ready_reg <= 1'b1;
            adr_reg       <= '0;
            dat_reg       <= '0;
            we_reg        <= 1'b0;
            sel_reg       <= '0;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_reg       <= '0;
        end else begin
            case (state_reg)
                WBM_IDLE: begin
                    if (cmd_valid) begin
                        adr_reg       <= cmd_addr;
                        dat_reg       <= cmd_wdata;
                        we_reg        <= cmd_we;
                        sel_reg       <= cmd_be;
                        cyc_reg       <= 1'b1;
                        stb_reg       <= 1'b1;
                        cmd_ready_reg <= 1'b0;
                        state_reg     <= WBM_BUS;
                    end
                end

                WBM_BUS: begin
                    // Error beats ack, ack beats the timer on the same cycle.
                    if (wb_err_i) begin
                        rsp_reg.err   <= 1'b1;
                        rsp_reg.rdata <= '0;
                        cyc_reg       <= 1'b0;
                        stb_reg       <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= WBM_RESP;
                    end else if (wb_ack_i) begin
                        rsp_reg.err   <= 1'b0;
                        rsp_reg.rdata <= we_reg ? '0 : WBM_RDATA_W'(wb_dat_i);
                        cyc_reg       <= 1'b0;
                        stb_reg       <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= WBM_RESP;
                    end else if (timer_expired) begin
                        rsp_reg.err   <= 1'b1;
                        rsp_reg.rdata <= '0;
                        cyc_reg       <= 1'b0;
                        stb_reg       <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= WBM_RESP;
                    end
                end

                WBM_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= WBM_IDLE;
                    end
                end

                default: begin
                    cyc_reg       <= 1'b0;
                    stb_reg       <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= WBM_IDLE;
                end
            endcase
        end
    end

    // The response record may be wider than this bus; only the low bits are presented.
    logic rsp_rdata_unused;
    assign rsp_rdata_unused = ^rsp_reg.rdata;

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_reg.rdata[DATA_WIDTH-1:0];
    assign rsp_err   = rsp_reg.err;
    assign wb_adr_o  = adr_reg;
    assign wb_dat_o  = dat_reg;
    assign wb_we_o   = we_reg;
    assign wb_sel_o  = sel_reg;
    assign wb_cyc_o  = cyc_reg;
    assign wb_stb_o  = stb_reg;
    assign busy      = (state_reg != WBM_IDLE);

endmodule
